// File: rtl/inv_mix_column_iter.sv
// AES-128 InvMixColumns stage: accepts one state, transforms COLS_PER_CYCLE columns per
// cycle in place, then holds the result on a valid/ready output until consumed.
module inv_mix_column_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("inv_mix_column_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  state_t       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] data_q, data_d;
  logic [127:0] mixed;
  logic [2:0]   col_next;
  logic         last_step;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 is the most significant byte of the column word.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] r [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      r[i]  = c[31-8*i -: 8];
      x2    = xtime(r[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ r[i];
      mb[i] = x8 ^ x2 ^ r[i];
      md[i] = x8 ^ x4 ^ r[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Only the columns in the current window are replaced; the rest pass through untouched.
  always_comb begin
    mixed = data_q;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(col_q) && k < int'(col_q) + COLS_PER_CYCLE) begin
        mixed[32*k +: 32] = inv_mix_col(data_q[32*k +: 32]);
      end
    end
  end

  assign col_next  = {1'b0, col_q} + STEP;
  assign last_step = col_next[2];
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          data_d  = in_data;
          col_d   = 2'd0;
          state_d = BUSY;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        data_d = mixed;
        if (last_step) begin
          col_d   = 2'd0;
          state_d = DONE;
        end else begin
          col_d = col_next[1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = data_q;

endmodule
